load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_BYTES, 256, byte size of attached data memory; legal byte addresses are 0..MEM_BYTES-1.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  CPU access request present.
REQ-005 req_ready  output  1  unit idle and able to accept a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  zero-extend a load; ignored for word and stores.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_error  output  1  access rejected; valid with resp_valid.
REQ-014 mem_read, mem_write  output  1 each  memory read/write enables.
REQ-015 mem_size  output  2  memory access size, same encoding as req_size.
REQ-016 address  output  32  memory byte address.
REQ-017 write_data  output  32  memory write data.
REQ-018 read_data  input  32  memory read data; registered in memory, valid in the cycle after mem_read is sampled; byte/halfword reads arrive sign-extended.

Function
REQ-019 States IDLE, ISSUE, CAPTURE, RESP; req_ready = 1 only in IDLE.
REQ-020 Acceptance: req_valid && req_ready at a rising edge latches all req_* fields; req_* ignored at every other time.
REQ-021 Error check at acceptance: req_size==11, or any byte req_addr..req_addr+N-1 >= MEM_BYTES (computed 33-bit, no wrap) -> RESP with resp_error=1, no memory access.
REQ-022 Aligned = byte, halfword with addr[0]==0, or word with addr[1:0]==00; aligned access = 1 beat at req_size; misaligned = 2 (half) or 4 (word) byte beats at req_addr+k, k ascending from 0.
REQ-023 ISSUE (1 cycle per beat): assert exactly one of mem_read/mem_write; address = base+k; mem_size = req_size if aligned else 00; write_data = req_wdata if aligned else {24'b0, byte k of req_wdata}.
REQ-024 Store: ISSUE -> ISSUE (k+1) until last beat, then RESP.
REQ-025 Load: ISSUE -> CAPTURE; in CAPTURE all mem_* outputs 0, read_data captured at end of cycle (byte k from [7:0] when split); then next ISSUE or RESP after last beat.
REQ-026 Load result: byte/half sign- or zero-extended per req_unsigned from assembled little-endian bytes; word unmodified.
REQ-027 RESP: resp_valid=1 for exactly one cycle, then IDLE; no response back-pressure.
REQ-028 Latency from acceptance edge to resp_valid cycle: error 1, aligned store 2, aligned load 3, split store 3/5, split load 5/9 (half/word).
REQ-029 mem_read, mem_write, resp_valid are 0 in every state not listed above; never two accesses in one cycle.

Reset
REQ-030 rst_n low immediately forces IDLE, k=0, all outputs and captured data 0, req_ready 0 while rst_n low, 1 after release.
REQ-031 Reset mid-transaction abandons it: no resp_valid, no further memory access; beats already written remain in memory.

Verification
REQ-032 Word store 0xDEADBEEF @0x10 then word load @0x10 -> single beats, resp_rdata 0xDEADBEEF, resp_valid 3rd cycle after load accept.
REQ-033 Byte 0x80 @0x05: signed load -> 0xFFFFFF80; unsigned -> 0x00000080; unsigned half load of 0x8001 @0x06 -> 0x00008001.
REQ-034 Word store 0x11223344 @0x21 -> byte writes 0x44,0x33,0x22,0x11 @0x21..0x24; word load @0x21 -> 0x11223344 on 9th cycle.
REQ-035 Word load @0xFE (MEM_BYTES=256) and any req_size=11 -> no mem access, resp_error=1, resp_rdata 0, resp_valid 1st cycle after accept.
REQ-036 rst_n low during CAPTURE of split load -> outputs 0 at once, no resp_valid; next aligned load completes correctly.
REQ-037 req_valid held high while busy -> req_ready 0, second request accepted only at the edge after RESP.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU byte/half/word requests into memory beats,
// splitting misaligned accesses into ascending single-byte beats.
module load_store_unit #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  logic [1:0]  state_reg, state_next;
  logic [1:0]  beat_reg, beat_next;
  logic        write_reg;
  logic        unsigned_reg;
  logic        aligned_reg;
  logic        error_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [7:0]  lane_reg [4];

  logic        accept;
  logic [1:0]  req_span;
  logic [32:0] req_last_byte;
  logic        req_error;
  logic        req_aligned;
  logic [1:0]  final_beat;
  logic        last_beat;
  logic [31:0] data_word;
  logic [31:0] load_value;

  assign req_ready = rst_n && (state_reg == IDLE);
  assign accept    = req_valid && req_ready;

  // Range check is done on a 33-bit sum so an address near 2^32 cannot wrap into range.
  always_comb begin
    req_span    = 2'd0;
    req_aligned = 1'b1;
    case (req_size)
      SIZE_HALF: begin
        req_span    = 2'd1;
        req_aligned = (req_addr[0] == 1'b0);
      end
      SIZE_WORD: begin
        req_span    = 2'd3;
        req_aligned = (req_addr[1:0] == 2'b00);
      end
      default: begin
        req_span    = 2'd0;
        req_aligned = 1'b1;
      end
    endcase
  end

  assign req_last_byte = {1'b0, req_addr} + {31'b0, req_span};
  assign req_error     = (req_size == SIZE_ILLEGAL) || (req_last_byte >= 33'(MEM_BYTES));

  always_comb begin
    final_beat = 2'd0;
    if (!aligned_reg) begin
      final_beat = (size_reg == SIZE_HALF) ? 2'd1 : 2'd3;
    end
  end

  assign last_beat = (beat_reg == final_beat);

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = req_error ? RESP : ISSUE;
          beat_next  = 2'd0;
        end
      end
      ISSUE: begin
        if (!write_reg) begin
          state_next = CAPTURE;
        end else if (last_beat) begin
          state_next = RESP;
        end else begin
          beat_next = beat_reg + 2'd1;
        end
      end
      CAPTURE: begin
        if (last_beat) begin
          state_next = RESP;
        end else begin
          state_next = ISSUE;
          beat_next  = beat_reg + 2'd1;
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      beat_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg    <= 1'b0;
      unsigned_reg <= 1'b0;
      aligned_reg  <= 1'b0;
      error_reg    <= 1'b0;
      size_reg     <= 2'b00;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
    end else if (accept) begin
      write_reg    <= req_write;
      unsigned_reg <= req_unsigned;
      aligned_reg  <= req_aligned;
      error_reg    <= req_error;
      size_reg     <= req_size;
      addr_reg     <= req_addr;
      wdata_reg    <= req_wdata;
    end
  end

  // Each byte lane loads either from its own slice (aligned beat) or from
  // read_data[7:0] when the current split beat targets that lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg[gi] <= 8'd0;
        end else if (accept) begin
          lane_reg[gi] <= 8'd0;
        end else if (state_reg == CAPTURE) begin
          if (aligned_reg) begin
            lane_reg[gi] <= read_data[8*gi +: 8];
          end else if (beat_reg == 2'(gi)) begin
            lane_reg[gi] <= read_data[7:0];
          end
        end
      end
    end
  endgenerate

  assign data_word = {lane_reg[3], lane_reg[2], lane_reg[1], lane_reg[0]};

  always_comb begin
    load_value = data_word;
    case (size_reg)
      SIZE_BYTE: load_value = unsigned_reg ? {24'd0, data_word[7:0]}
                                           : {{24{data_word[7]}}, data_word[7:0]};
      SIZE_HALF: load_value = unsigned_reg ? {16'd0, data_word[15:0]}
                                           : {{16{data_word[15]}}, data_word[15:0]};
      default:   load_value = data_word;
    endcase
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_size   = SIZE_BYTE;
    address    = 32'd0;
    write_data = 32'd0;
    if (state_reg == ISSUE) begin
      mem_read  = !write_reg;
      mem_write = write_reg;
      mem_size  = aligned_reg ? size_reg : SIZE_BYTE;
      address   = addr_reg + {30'd0, beat_reg};
      if (write_reg) begin
        write_data = aligned_reg ? wdata_reg : {24'd0, wdata_reg[{beat_reg, 3'b000} +: 8]};
      end
    end
  end

  assign resp_valid = (state_reg == RESP);
  assign resp_error = (state_reg == RESP) && error_reg;
  assign resp_rdata = ((state_reg == RESP) && !error_reg && !write_reg) ? load_value : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered byte-addressed memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .address(address), .write_data(write_data),
    .read_data(read_data)
  );

  // Memory model: registered read, byte/half reads returned sign-extended
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_write && address < 256) begin
      mem[address[7:0]] <= write_data[7:0];
      if (mem_size != 2'b00) mem[address[7:0] + 8'd1] <= write_data[15:8];
      if (mem_size == 2'b10) begin
        mem[address[7:0] + 8'd2] <= write_data[23:16];
        mem[address[7:0] + 8'd3] <= write_data[31:24];
      end
    end
    if (mem_read) begin
      case (mem_size)
        2'b00:   read_data <= {{24{mem[address[7:0]][7]}}, mem[address[7:0]]};
        2'b01:   read_data <= {{16{mem[address[7:0] + 8'd1][7]}}, mem[address[7:0] + 8'd1], mem[address[7:0]]};
        default: read_data <= {mem[address[7:0] + 8'd3], mem[address[7:0] + 8'd2],
                               mem[address[7:0] + 8'd1], mem[address[7:0]]};
      endcase
    end
  end

  // Access monitor: cumulative counts and a write log
  int rd_total = 0;
  int wr_total = 0;
  int both_total = 0;
  logic [31:0] wlog_addr [64];
  logic [31:0] wlog_data [64];
  logic [1:0]  wlog_size [64];
  always @(negedge clk) begin
    if (mem_read && mem_write) both_total <= both_total + 1;
    if (mem_read) rd_total <= rd_total + 1;
    if (mem_write) begin
      wlog_addr[wr_total % 64] <= address;
      wlog_data[wr_total % 64] <= write_data;
      wlog_size[wr_total % 64] <= mem_size;
      wr_total <= wr_total + 1;
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nrd, output int nwr);
    int r0, w0, guard;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    r0 = rd_total; w0 = wr_total;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; rd = 32'd0; er = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_error;
        break;
      end
    end
    nrd = rd_total - r0;
    nwr = wr_total - w0;
    $display("txn wr=%0b size=%0d uns=%0b addr=%08h wdata=%08h -> lat=%0d rdata=%08h err=%0b reads=%0d writes=%0d",
             wr, sz, uns, a, wd, lat, rd, er, nrd, nwr);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low: got %b expected 0", req_ready); end
    checks++; if ({resp_valid, resp_error, mem_read, mem_write} !== 4'b0) begin failures++; $display("FAIL reset_ctrl: got %b expected 0000", {resp_valid, resp_error, mem_read, mem_write}); end
    checks++; if ({resp_rdata, address, write_data} !== 96'd0) begin failures++; $display("FAIL reset_data: got %h expected 0", {resp_rdata, address, write_data}); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_release: got %b expected 1", req_ready); end
  endtask

  task automatic test_aligned_word();
    int lat, nrd, nwr; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, nrd, nwr);
    checks++; if (lat !== 2) begin failures++; $display("FAIL word_store_lat: got %0d expected 2", lat); end
    checks++; if (nwr !== 1 || nrd !== 0) begin failures++; $display("FAIL word_store_beats: got w%0d r%0d expected w1 r0", nwr, nrd); end
    checks++; if ({wlog_addr[(wr_total-1)%64], wlog_size[(wr_total-1)%64], wlog_data[(wr_total-1)%64]} !== {32'h10, 2'b10, 32'hDEADBEEF})
      begin failures++; $display("FAIL word_store_bus: got %h/%0d/%h expected 10/2/deadbeef", wlog_addr[(wr_total-1)%64], wlog_size[(wr_total-1)%64], wlog_data[(wr_total-1)%64]); end
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin failures++; $display("FAIL word_store_resp: got %h err %b expected 0 err 0", rd, er); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, nrd, nwr);
    checks++; if (lat !== 3) begin failures++; $display("FAIL word_load_lat: got %0d expected 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL word_load_data: got %h expected deadbeef", rd); end
    checks++; if (nrd !== 1 || nwr !== 0) begin failures++; $display("FAIL word_load_beats: got r%0d w%0d expected r1 w0", nrd, nwr); end
  endtask

  task automatic test_byte_half();
    int lat, nrd, nwr; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b00, 1'b0, 32'h05, 32'h12345680, lat, rd, er, nrd, nwr);
    checks++; if (lat !== 2 || nwr !== 1) begin failures++; $display("FAIL byte_store: got lat %0d w%0d expected lat 2 w1", lat, nwr); end
    do_req(1'b0, 2'b00, 1'b0, 32'h05, 32'h0, lat, rd, er, nrd, nwr);
    checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL byte_load_signed: got %h expected ffffff80", rd); end
    do_req(1'b0, 2'b00, 1'b1, 32'h05, 32'h0, lat, rd, er, nrd, nwr);
    checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL byte_load_unsigned: got %h expected 00000080", rd); end
    do_req(1'b1, 2'b01, 1'b0, 32'h06, 32'hABCD8001, lat, rd, er, nrd, nwr);
    checks++; if (lat !== 2 || nwr !== 1) begin failures++; $display("FAIL half_store: got lat %0d w%0d expected lat 2 w1", lat, nwr); end
    do_req(1'b0, 2'b01, 1'b1, 32'h06, 32'h0, lat, rd, er, nrd, nwr);
    checks++; if (rd !== 32'h00008001 || lat !== 3) begin failures++; $display("FAIL half_load_unsigned: got %h lat %0d expected 00008001 lat 3", rd, lat); end
    do_req(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, lat, rd, er, nrd, nwr);
    checks++; if (rd !== 32'hFFFF8001) begin failures++; $display("FAIL half_load_signed: got %h expected ffff8001", rd); end
  endtask

  task automatic test_split();
    int lat, nrd, nwr, w0; logic [31:0] rd; logic er;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
    w0 = wr_total;
    do_req(1'b1, 2'b10, 1'b0, 32'h21, 32'h11223344, lat, rd, er, nrd, nwr);
    checks++; if (lat !== 5 || nwr !== 4) begin failures++; $display("FAIL split_word_store: got lat %0d w%0d expected lat 5 w4", lat, nwr); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wlog_addr[(w0+i)%64] !== 32'h21 + i || wlog_data[(w0+i)%64] !== {24'd0, exp_b[i]} || wlog_size[(w0+i)%64] !== 2'b00) begin
        failures++;
        $display("FAIL split_store_beat%0d: got %h/%h/%0d expected %h/%h/0", i, wlog_addr[(w0+i)%64], wlog_data[(w0+i)%64], wlog_size[(w0+i)%64], 32'h21 + i, exp_b[i]);
      end
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, lat, rd, er, nrd, nwr);
    checks++; if (lat !== 9) begin failures++; $display("FAIL split_word_load_lat: got %0d expected 9", lat); end
    checks++; if (rd !== 32'h11223344 || nrd !== 4) begin failures++; $display("FAIL split_word_load: got %h r%0d expected 11223344 r4", rd, nrd); end
    do_req(1'b1, 2'b01, 1'b0, 32'h31, 32'h0000A5B6, lat, rd, er, nrd, nwr);
    checks++; if (lat !== 3 || nwr !== 2) begin failures++; $display("FAIL split_half_store: got lat %0d w%0d expected lat 3 w2", lat, nwr); end
    do_req(1'b0, 2'b01, 1'b0, 32'h31, 32'h0, lat, rd, er, nrd, nwr);
    checks++; if (lat !== 5 || rd !== 32'hFFFFA5B6) begin failures++; $display("FAIL split_half_load_signed: got %h lat %0d expected ffffa5b6 lat 5", rd, lat); end
    do_req(1'b0, 2'b01, 1'b1, 32'h31, 32'h0, lat, rd, er, nrd, nwr);
    checks++; if (rd !== 32'h0000A5B6) begin failures++; $display("FAIL split_half_load_unsigned: got %h expected 0000a5b6", rd); end
  endtask

  task automatic test_error();
    int lat, nrd, nwr; logic [31:0] rd; logic er;
    do_req(1'b0, 2'b10, 1'b0, 32'hFE, 32'h0, lat, rd, er, nrd, nwr);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || nrd + nwr !== 0)
      begin failures++; $display("FAIL err_word_fe: got lat %0d err %b rd %h acc %0d expected lat 1 err 1 rd 0 acc 0", lat, er, rd, nrd + nwr); end
    do_req(1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFFFFFF, lat, rd, er, nrd, nwr);
    checks++; if (lat !== 1 || er !== 1'b1 || nrd + nwr !== 0)
      begin failures++; $display("FAIL err_size11: got lat %0d err %b acc %0d expected lat 1 err 1 acc 0", lat, er, nrd + nwr); end
    do_req(1'b0, 2'b01, 1'b0, 32'hFF, 32'h0, lat, rd, er, nrd, nwr);
    checks++; if (er !== 1'b1 || nrd !== 0) begin failures++; $display("FAIL err_half_ff: got err %b r%0d expected err 1 r0", er, nrd); end
    do_req(1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, lat, rd, er, nrd, nwr);
    checks++; if (er !== 1'b1 || nrd !== 0) begin failures++; $display("FAIL err_nowrap: got err %b r%0d expected err 1 r0", er, nrd); end
    do_req(1'b1, 2'b00, 1'b0, 32'hFF, 32'h0000005A, lat, rd, er, nrd, nwr);
    checks++; if (er !== 1'b0 || lat !== 2 || nwr !== 1) begin failures++; $display("FAIL edge_byte_ff_store: got err %b lat %0d w%0d expected err 0 lat 2 w1", er, lat, nwr); end
    do_req(1'b0, 2'b00, 1'b1, 32'hFF, 32'h0, lat, rd, er, nrd, nwr);
    checks++; if (er !== 1'b0 || rd !== 32'h5A) begin failures++; $display("FAIL edge_byte_ff_load: got err %b rd %h expected err 0 rd 0000005a", er, rd); end
    do_req(1'b1, 2'b10, 1'b0, 32'hFC, 32'h01020304, lat, rd, er, nrd, nwr);
    checks++; if (er !== 1'b0 || lat !== 2) begin failures++; $display("FAIL edge_word_fc: got err %b lat %0d expected err 0 lat 2", er, lat); end
  endtask

  task automatic test_reset_mid();
    int lat, nrd, nwr, r0, w0; logic [31:0] rd; logic er; logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL midrst_issue: got mem_read %b expected 1", mem_read); end
    @(negedge clk);
    r0 = rd_total; w0 = wr_total;
    rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, resp_valid, mem_read, mem_write} !== 4'b0 || {address, write_data, resp_rdata} !== 96'd0)
      begin failures++; $display("FAIL midrst_outputs: got %b %h expected 0", {req_ready, resp_valid, mem_read, mem_write}, {address, write_data, resp_rdata}); end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (12) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_resp: got resp_valid seen %b expected 0", seen); end
    checks++; if (rd_total - r0 !== 0 || wr_total - w0 !== 0) begin failures++; $display("FAIL midrst_no_access: got r%0d w%0d expected r0 w0", rd_total - r0, wr_total - w0); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, nrd, nwr);
    checks++; if (lat !== 3 || rd !== 32'hDEADBEEF) begin failures++; $display("FAIL midrst_recover: got %h lat %0d expected deadbeef lat 3", rd, lat); end
  endtask

  task automatic test_back_to_back();
    int r0, w0, guard;
    logic rdy [13];
    logic rv [13];
    logic [31:0] rdat [13];
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    r0 = rd_total; w0 = wr_total;
    @(posedge clk);
    #1 req_write = 1'b0; req_wdata = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      rdy[c] = req_ready; rv[c] = resp_valid; rdat[c] = resp_rdata;
      if (c == 4) req_valid = 1'b0;
    end
    $display("txn back-to-back store+load @40: ready=%b%b%b%b resp=%b%b%b%b%b rdata6=%08h",
             rdy[1], rdy[2], rdy[3], rdy[4], rv[2], rv[3], rv[4], rv[5], rv[6], rdat[6]);
    checks++; if ({rdy[1], rdy[2], rdy[3], rdy[4]} !== 4'b0010) begin failures++; $display("FAIL b2b_ready: got %b expected 0010", {rdy[1], rdy[2], rdy[3], rdy[4]}); end
    checks++; if ({rv[1], rv[2], rv[3], rv[4], rv[5], rv[6], rv[7]} !== 7'b0100010) begin failures++; $display("FAIL b2b_resp_timing: got %b expected 0100010", {rv[1], rv[2], rv[3], rv[4], rv[5], rv[6], rv[7]}); end
    checks++; if (rdat[2] !== 32'd0) begin failures++; $display("FAIL b2b_store_rdata: got %h expected 0", rdat[2]); end
    checks++; if (rdat[6] !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_load_rdata: got %h expected cafef00d", rdat[6]); end
    checks++; if (wr_total - w0 !== 1 || rd_total - r0 !== 1) begin failures++; $display("FAIL b2b_accesses: got w%0d r%0d expected w1 r1", wr_total - w0, rd_total - r0); end
  endtask

  initial begin
    test_reset();
    test_aligned_word();
    test_byte_half();
    test_split();
    test_error();
    test_reset_mid();
    test_back_to_back();
    checks++; if (both_total !== 0) begin failures++; $display("FAIL dual_access: got %0d cycles expected 0", both_total); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
